ysyx_25040105_ifu: RTL and testbench



---
 rtl/ysyx_25040105_pkg.sv | 7 +
 rtl/ysyx_25040105_ifu_pc.sv | 20 ++
 rtl/ysyx_25040105_ifu.sv | 98 +++++++++
 tb/tb_ysyx_25040105_ifu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040105_pkg.sv
// ysyx_25040105_pkg: shared types and constants for the instruction fetch unit
package ysyx_25040105_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, REQ, WAIT, OUT} ifu_state_t;
endpackage

// File: rtl/ysyx_25040105_ifu_pc.sv
// ysyx_25040105_ifu_pc: program counter with +4 advance and redirect override
module ysyx_25040105_ifu_pc import ysyx_25040105_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] pc_q, pc_d;
    // a redirect always beats a sequential advance
    assign pc_d = redirect_valid ? redirect_pc : advance ? pc_q + 32'd4 : pc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
    assign pc = pc_q;
endmodule

// File: rtl/ysyx_25040105_ifu.sv
// ysyx_25040105_ifu: one-in-flight instruction fetch with redirect squash
module ysyx_25040105_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    import ysyx_25040105_pkg::*;
    ifu_state_t  state_q, state_d;
    logic        drop_q, drop_d, fault_q, fault_d, misaligned;
    logic [31:0] inst_q, inst_d, inst_pc_q, inst_pc_d, pc;
    ysyx_25040105_ifu_pc #(.RESET_PC(RESET_PC)) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (inst_valid && inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );
    assign misaligned      = pc[1:0] != 2'b00;
    assign imem_req_valid  = state_q == REQ && !misaligned;
    assign imem_req_addr   = pc;
    assign imem_resp_ready = state_q == WAIT;
    assign inst_valid      = state_q == OUT;
    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign inst_fault      = fault_q;
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        unique case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (redirect_valid) begin
                    // an accepted request for the old pc must be discarded on return
                    if (imem_req_valid && imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (misaligned) begin
                    state_d   = OUT;
                    inst_d    = NOP_INST;
                    fault_d   = 1'b1;
                    inst_pc_d = pc;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d = (redirect_valid || drop_q) ? REQ : OUT;
                    drop_d  = 1'b0;
                    if (!redirect_valid && !drop_q) begin
                        inst_d    = imem_resp_err ? NOP_INST : imem_resp_data;
                        fault_d   = imem_resp_err;
                        inst_pc_d = pc;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            OUT: state_d = (redirect_valid || inst_ready) ? REQ : OUT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            drop_q    <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= RESET_PC;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// tb_ysyx_25040105_ifu: directed and random fetch-stream checks against a program-order model
module tb_ysyx_25040105_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0, imem_resp_ready, imem_resp_err = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid, inst_ready = 1'b0, inst_fault;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    always #5 clk = ~clk;

    ysyx_25040105_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int n_chk = 0, n_fail = 0, n_hs = 0;
    logic        k_ready = 1'b0, k_irdy = 1'b0, k_rdir = 1'b0;
    logic [31:0] k_rpc = 32'd0;
    int          k_delay = 0;
    logic        pend = 1'b0, stray = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'd0, exp_pc = RST_PC;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a == RST_PC ? 32'h0010_0093 : a == 32'h8000_0004 ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic errf(input logic [31:0] a);
        return a[6:2] == 5'd9;
    endfunction
    function automatic logic bad(input logic [31:0] p);
        return p[1:0] != 2'b00 || errf(p);
    endfunction

    // one cycle: sample outputs, drive inputs, then advance the program-order model
    task automatic tick();
        logic rv, rr, iv, flt, rdir;
        logic [31:0] ra, ipc, ins, rpc;
        rv = imem_req_valid; ra = imem_req_addr; rr = imem_resp_ready;
        iv = inst_valid; ipc = inst_pc; ins = inst; flt = inst_fault;
        rdir = k_rdir; rpc = k_rpc; k_rdir = 1'b0;
        imem_req_ready  = k_ready && !pend;
        imem_resp_valid = pend && cnt == 0;
        imem_resp_data  = memf(pend_addr);
        imem_resp_err   = pend && errf(pend_addr);
        redirect_valid  = rdir; redirect_pc = rpc; inst_ready = k_irdy;
        if (!rst_n) begin
            exp_pc = RST_PC;
            if (pend) begin stray = 1'b1; cnt = 0; end
        end else begin
            if (rv && imem_req_ready) begin
                check("req_addr", ra, exp_pc);
                check("req_align", {30'd0, ra[1:0]}, 32'd0);
                check("req_no_resp_rdy", {31'd0, rr}, 32'd0);
                pend = 1'b1; stray = 1'b0; cnt = k_delay; pend_addr = ra;
            end else if (imem_resp_valid && (rr || stray)) begin
                pend = 1'b0; stray = 1'b0;
            end else if (pend && cnt > 0) cnt--;
            if (iv && k_irdy && !rdir) begin
                check("dec_pc", ipc, exp_pc);
                check("dec_inst", ins, bad(exp_pc) ? NOP : memf(exp_pc));
                check("dec_fault", {31'd0, flt}, {31'd0, bad(exp_pc)});
                exp_pc += 32'd4;
                n_hs++;
            end
            if (rdir) exp_pc = rpc;
        end
        @(negedge clk);
    endtask

    function automatic logic cur(input int sel);
        return sel == 0 ? inst_valid : sel == 1 ? imem_req_valid : imem_resp_ready;
    endfunction

    task automatic wait_sig(input string tag, input int sel, input int max);
        int i = 0;
        while (i < max && !cur(sel)) begin tick(); i++; end
        check(tag, {31'd0, cur(sel)}, 32'd1);
    endtask

    initial begin
        int hs0;
        logic [31:0] held;
        repeat (2) tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, RST_PC);
        check("rst_fault", {31'd0, inst_fault}, 32'd0);
        rst_n = 1'b1; k_ready = 1'b1; k_delay = 0;
        tick();
        check("boot_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("boot_req_addr", imem_req_addr, RST_PC);
        tick(); tick();
        check("first_valid", {31'd0, inst_valid}, 32'd1);
        check("first_inst", inst, 32'h0010_0093);
        check("first_pc", inst_pc, RST_PC);
        held = inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst", inst, held);
            check("stall_pc", inst_pc, RST_PC);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        k_irdy = 1'b1; tick(); k_irdy = 1'b0;
        check("next_req_addr", imem_req_addr, 32'h8000_0004);
        k_delay = 3; tick();
        k_rdir = 1'b1; k_rpc = 32'h8000_0100; tick();
        for (int i = 0; i < 10 && !imem_req_valid; i++) begin
            check("squash_no_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        check("squash_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("squash_req_addr", imem_req_addr, 32'h8000_0100);
        k_delay = 0;
        wait_sig("wait_valid_a", 0, 10);
        k_irdy = 1'b1; k_rdir = 1'b1; k_rpc = 32'h8000_0200; tick(); k_irdy = 1'b0;
        check("redir_hs_valid", {31'd0, inst_valid}, 32'd0);
        check("redir_hs_addr", imem_req_addr, 32'h8000_0200);
        k_rdir = 1'b1; k_rpc = 32'h8000_0024; tick();
        wait_sig("wait_valid_err", 0, 20);
        check("err_inst", inst, NOP);
        check("err_fault", {31'd0, inst_fault}, 32'd1);
        check("err_pc", inst_pc, 32'h8000_0024);
        k_rdir = 1'b1; k_rpc = 32'h8000_0002; tick();
        check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("mis_valid", {31'd0, inst_valid}, 32'd1);
        check("mis_fault", {31'd0, inst_fault}, 32'd1);
        check("mis_pc", inst_pc, 32'h8000_0002);
        check("mis_inst", inst, NOP);
        k_rdir = 1'b1; k_rpc = 32'hFFFF_FFFC; tick();
        wait_sig("wait_valid_wrap", 0, 20);
        k_irdy = 1'b1; tick(); k_irdy = 1'b0;
        check("wrap_req_addr", imem_req_addr, 32'd0);
        k_delay = 3;
        wait_sig("wait_resp_ready", 2, 10);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mid_rst_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_req_addr, RST_PC);
        check("mid_rst_inst_pc", inst_pc, RST_PC);
        k_delay = 0;
        wait_sig("wait_valid_restart", 0, 20);
        check("restart_inst", inst, 32'h0010_0093);
        check("restart_pc", inst_pc, RST_PC);
        hs0 = n_hs;
        for (int i = 0; i < 3000; i++) begin
            k_ready = $urandom_range(0, 3) != 0;
            k_delay = $urandom_range(0, 3);
            k_irdy  = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 15) == 0) begin
                k_rdir = 1'b1;
                k_rpc  = RST_PC + ($urandom_range(0, 255) << 2) + ($urandom_range(0, 5) == 0 ? 32'd2 : 32'd0);
            end
            if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        check("random_progress", {31'd0, (n_hs - hs0) > 150}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
